// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths, depths and a constant log2 helper
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_TXFIFO_DEPTH = 16;

  // Ceiling log2 for sizing pointers from a depth; usable in parameter expressions.
  function automatic int uart_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_W register array, one write port, one async read port
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - show-ahead byte FIFO feeding the UART transmitter, with level and sticky error flags
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = UART_TXFIFO_DEPTH,
  parameter int ADDR_W   = uart_clog2(DEPTH),
  parameter int AFULL_TH = 12
) (
  input  logic              glb_clk,
  input  logic              glb_rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              FIFO_r_en,
  output logic [DATA_W-1:0] Tx_data_o,
  output logic              FIFO_ctrl_empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_TH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_ok, pop_ok, mem_we;

  // Qualified against the registered flags only; no same-cycle bypass.
  assign push_ok = wr_en & ~full_q;
  assign pop_ok  = FIFO_r_en & ~empty_q;
  assign mem_we  = push_ok & ~flush & ~glb_rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
      if (wr_en && full_q)       ovf_d = 1'b1;
      if (FIFO_r_en && empty_q)  udf_d = 1'b1;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
    afull_d = (count_d >= AFULL_CNT);
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (glb_clk),
    .we      (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (Tx_data_o)
  );

  assign FIFO_ctrl_empty = empty_q;
  assign full            = full_q;
  assign almost_full     = afull_q;
  assign count           = count_q;
  assign overflow        = ovf_q;
  assign underflow       = udf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized bench for uart_tx_fifo against a queue-based reference model
module tb_uart_tx_fifo;

  logic       glb_clk = 1'b0;
  logic       glb_rst = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       FIFO_r_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] Tx_data_o;
  logic       FIFO_ctrl_empty, full, almost_full, overflow, underflow;
  logic [4:0] count;

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  bit         m_ovf, m_udf;

  always #5 glb_clk = ~glb_clk;

  uart_tx_fifo dut (
    .glb_clk         (glb_clk),
    .glb_rst         (glb_rst),
    .flush           (flush),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .FIFO_r_en       (FIFO_r_en),
    .Tx_data_o       (Tx_data_o),
    .FIFO_ctrl_empty (FIFO_ctrl_empty),
    .full            (full),
    .almost_full     (almost_full),
    .count           (count),
    .overflow        (overflow),
    .underflow       (underflow),
    .clr_err         (clr_err)
  );

  // One clock with the given inputs; the model follows the FIFO rules on occupancy alone.
  task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit fl, input bit ce);
    int n;
    n = mq.size();
    wr_en = w; wr_data = wd; FIFO_r_en = r; flush = fl; clr_err = ce;
    @(posedge glb_clk);
    #1;
    wr_en = 1'b0; FIFO_r_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    if (ce) begin m_ovf = 0; m_udf = 0; end
    if (fl) mq.delete();
    else begin
      if (w && n == 16) m_ovf = 1;
      if (r && n == 0) m_udf = 1;
      if (r && n != 0) void'(mq.pop_front());
      if (w && n != 16) mq.push_back(wd);
    end
  endtask

  task automatic test_reset();
    glb_rst = 1'b1;
    repeat (2) @(posedge glb_clk);
    #1;
    glb_rst = 1'b0;
    mq.delete(); m_ovf = 0; m_udf = 0;
    total++; if (FIFO_ctrl_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", FIFO_ctrl_empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_order();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hDF; exp_b[2] = 8'hE0;
    for (int i = 0; i < 3; i++) step(1, exp_b[i], 0, 0, 0);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (Tx_data_o !== exp_b[i]) begin bad++; $display("FAIL order_head%0d got=%h exp=%h", i, Tx_data_o, exp_b[i]); end
      step(0, 8'h00, 1, 0, 0);
      total++; if (int'(count) !== 2 - i) begin bad++; $display("FAIL order_cnt%0d got=%0d exp=%0d", i, count, 2 - i); end
    end
    total++; if (FIFO_ctrl_empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%b exp=1", FIFO_ctrl_empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      total++; if (almost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_afull n=%0d got=%b exp=%b", i + 1, almost_full, (i + 1 >= 12)); end
      total++; if (full !== (i + 1 == 16)) begin bad++; $display("FAIL fill_full n=%0d got=%b exp=%b", i + 1, full, (i + 1 == 16)); end
    end
    step(1, 8'hAA, 0, 0, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
    for (int i = 0; i < 16; i++) begin
      total++; if (Tx_data_o !== 8'(i)) begin bad++; $display("FAIL fill_drain%0d got=%h exp=%h", i, Tx_data_o, 8'(i)); end
      step(0, 8'h00, 1, 0, 0);
    end
    total++; if (FIFO_ctrl_empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL fill_end got=%b%b exp=10", FIFO_ctrl_empty, underflow); end
    step(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    total++; if (count !== 5'd15) begin bad++; $display("FAIL sim_full_count got=%0d exp=15", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sim_full_ovf got=%b exp=1", overflow); end
    total++; if (Tx_data_o !== 8'h01) begin bad++; $display("FAIL sim_full_head got=%h exp=01", Tx_data_o); end
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'h77, 1, 0, 0);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL sim_empty_count got=%0d exp=1", count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL sim_empty_udf got=%b exp=1", underflow); end
    total++; if (Tx_data_o !== 8'h77) begin bad++; $display("FAIL sim_empty_head got=%h exp=77", Tx_data_o); end
    // An error in the same cycle as clr_err keeps the flag set.
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 1);
    total++; if (underflow !== m_udf || m_udf !== 1'b1) begin bad++; $display("FAIL sim_clr_race got=%b exp=1", underflow); end
    step(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_wrap_random();
    logic [7:0] nxt;
    bit w, r;
    nxt = 8'($urandom);
    step(1, nxt, 0, 0, 0); nxt++;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() <= 1) begin w = 1; r = 0; end
      else if (mq.size() >= 5) begin w = 0; r = 1; end
      else begin w = 1'($urandom); r = 1'($urandom); end
      total++; if (Tx_data_o !== mq[0]) begin bad++; $display("FAIL wrap_head%0d got=%h exp=%h", i, Tx_data_o, mq[0]); end
      step(w, nxt, r, 0, 0);
      if (w) nxt++;
      total++; if (int'(count) !== mq.size() || FIFO_ctrl_empty !== (mq.size() == 0)) begin bad++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", i, count, mq.size()); end
    end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL wrap_flags got=%b%b exp=00", overflow, underflow); end
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0, 0);
    step(1, 8'h99, 1, 1, 0);
    total++; if (count !== 5'd0 || FIFO_ctrl_empty !== 1'b1) begin bad++; $display("FAIL flush_state got=%0d/%b exp=0/1", count, FIFO_ctrl_empty); end
    total++; if (underflow !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL flush_flags got=%b%b exp=01", overflow, underflow); end
    step(0, 8'h00, 0, 0, 1);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", underflow); end
  endtask

  // Stand-in for the transmitter: one pop per frame time whenever data is present.
  task automatic test_consumer();
    logic [7:0] got[$];
    int pops, cyc;
    for (int i = 0; i < 4; i++) step(1, 8'hDE + 8'(i), 0, 0, 0);
    pops = 0; cyc = 0;
    while (pops < 4 && cyc < 200) begin
      if (FIFO_ctrl_empty == 1'b0 && cyc % 11 == 0) begin
        got.push_back(Tx_data_o);
        total++; if (Tx_data_o !== mq[0]) begin bad++; $display("FAIL cons_head%0d got=%h exp=%h", pops, Tx_data_o, mq[0]); end
        step(0, 8'h00, 1, 0, 0);
        pops++;
      end else step(0, 8'h00, 0, 0, 0);
      cyc++;
    end
    total++; if (pops !== 4) begin bad++; $display("FAIL cons_pops got=%0d exp=4", pops); end
    total++; if (got.size() == 4 && got[3] !== 8'hE1) begin bad++; $display("FAIL cons_last got=%h exp=e1", got[3]); end
    total++; if (FIFO_ctrl_empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL cons_end got=%b%b exp=10", FIFO_ctrl_empty, underflow); end
  endtask

  initial begin
    @(posedge glb_clk);
    #1;
    test_reset();
    test_order();
    test_fill();
    test_simultaneous();
    test_wrap_random();
    test_consumer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
